// File: rtl/aes_block_packer_if.sv
// Byte-in / block-out stream bundle for aes_block_packer.
// The packer takes the slave side; the byte source and block sink sit on the master side.
interface aes_block_packer_if #(
  parameter int CNT_W = 32
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [127:0]     out_block;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic [CNT_W-1:0] block_count;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_block, out_valid, out_last, block_count
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_block, out_valid, out_last, block_count
  );
endinterface

// File: rtl/aes_block_packer.sv
// Packs a byte stream into 128-bit blocks for the encrypt core, applying PKCS#7
// padding (or zero fill) to the final block of each message.
module aes_block_packer #(
  parameter bit PAD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_block_packer_if.slave  bus
);

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    PAD
  } state_e;

  state_e           state_q;
  logic [3:0]       idx_q;
  logic [127:0]     asm_q;
  logic [127:0]     out_block_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             pad_pending_q;
  logic [CNT_W-1:0] cnt_q;

  logic [127:0]     blk_d;
  logic [7:0]       pad_byte;
  logic             final_slot;

  assign final_slot = (idx_q == 4'd15);
  assign pad_byte   = PAD_EN ? {4'h0, 4'd15 - idx_q} : 8'h00;

  // Current assembly with the incoming byte dropped into its slot and, when this
  // byte ends the message, every later slot overwritten with the fill value.
  // NOTE: blk_d gets a full default first so no path through this block can infer a latch.
  always_comb begin
    blk_d = asm_q;
    for (int i = 0; i < 16; i++) begin
      if (4'(i) == idx_q) begin
        blk_d[127-8*i -: 8] = bus.in_data;
      end else if (bus.in_last && (4'(i) > idx_q)) begin
        blk_d[127-8*i -: 8] = pad_byte;
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FILL;
      idx_q         <= 4'd0;
      asm_q         <= '0;
      out_block_q   <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      pad_pending_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (bus.in_valid) begin
            if (final_slot || bus.in_last) begin
              out_block_q   <= blk_d;
              out_valid_q   <= 1'b1;
              out_last_q    <= bus.in_last && (!final_slot || !PAD_EN);
              pad_pending_q <= bus.in_last && final_slot && PAD_EN;
              asm_q         <= '0;
              idx_q         <= 4'd0;
              state_q       <= EMIT;
            end else begin
              asm_q <= blk_d;
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (pad_pending_q) begin
              out_block_q <= {16{8'h10}};
              out_last_q  <= 1'b1;
              state_q     <= PAD;
            end else begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= FILL;
            end
          end
        end
        PAD: begin
          if (bus.out_ready) begin
            cnt_q         <= cnt_q + CNT_W'(1);
            pad_pending_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            state_q       <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // in_ready is decoded from state so it drops immediately while reset is held.
  assign bus.in_ready    = rst_n && (state_q == FILL);
  assign bus.out_block   = out_block_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.block_count = cnt_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: one padding and one zero-fill instance,
// expected blocks built from each message by a byte-level model.
module tb_aes_block_packer;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [127:0] blk;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel;  // 0 selects the padding instance, 1 the zero-fill instance
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;

  int tests_run = 0;
  int fails = 0;
  exp_t exp_q[$];

  aes_block_packer_if #(.CNT_W(32)) if_p ();
  aes_block_packer_if #(.CNT_W(32)) if_n ();

  assign if_p.in_data   = in_data;
  assign if_p.in_valid  = in_valid & ~sel;
  assign if_p.in_last   = in_last;
  assign if_p.out_ready = out_ready & ~sel;
  assign if_n.in_data   = in_data;
  assign if_n.in_valid  = in_valid & sel;
  assign if_n.in_last   = in_last;
  assign if_n.out_ready = out_ready & sel;

  wire         in_ready    = sel ? if_n.in_ready    : if_p.in_ready;
  wire         out_valid   = sel ? if_n.out_valid   : if_p.out_valid;
  wire         out_last    = sel ? if_n.out_last    : if_p.out_last;
  wire [127:0] out_block   = sel ? if_n.out_block   : if_p.out_block;
  wire [31:0]  block_count = sel ? if_n.block_count : if_p.block_count;

  aes_block_packer #(.PAD_EN(1'b1), .CNT_W(32)) u_pad (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_p)
  );

  aes_block_packer #(.PAD_EN(1'b0), .CNT_W(32)) u_nopad (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_n)
  );

  // Block sink: every block about to be accepted is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_block got %h last=%b, none expected", out_block, out_last);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_block !== e.blk || out_last !== e.last) begin
          fails++;
          $display("FAIL block got %h last=%b, expected %h last=%b",
                   out_block, out_last, e.blk, e.last);
        end
      end
    end
  end

  // Reference model: splits a message into 16-byte blocks, padding the tail
  // (PKCS#7 or zero) when the message is terminated.
  function automatic void push_expected(input byte_q_t msg, input bit pad_en, input bit has_last);
    int len;
    int nblk;
    int pad;
    logic [127:0] blk;
    len  = msg.size();
    nblk = !has_last ? len / 16 : (pad_en ? len / 16 + 1 : (len + 15) / 16);
    pad  = nblk * 16 - len;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int s = 0; s < 16; s++) begin
        int k;
        k = b * 16 + s;
        blk[127-8*s -: 8] = (k < len) ? msg[k] : (pad_en ? 8'(pad) : 8'h00);
      end
      exp_q.push_back('{blk: blk, last: has_last && (b == nblk - 1)});
    end
  endfunction

  function automatic byte_q_t ramp(input logic [7:0] first, input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(first + 8'(i));
    return q;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests_run++;
      fails++;
      $display("FAIL send_timeout byte %h never accepted", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input byte_q_t msg, input bit has_last, input bit gap);
    for (int i = 0; i < msg.size(); i++) begin
      send_byte(msg[i], has_last && (i == msg.size() - 1));
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      fails++;
      $display("FAIL drain_timeout %0d blocks still expected", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_count(input string name, input logic [31:0] exp);
    tests_run++;
    if (block_count !== exp) begin
      fails++;
      $display("FAIL %s block_count got %0d expected %0d", name, block_count, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (if_p.in_ready !== 1'b0 || if_n.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_ready got %b/%b expected 0/0", if_p.in_ready, if_n.in_ready);
    end
    tests_run++;
    if (if_p.out_valid !== 1'b0 || if_p.out_last !== 1'b0 || if_p.out_block !== '0 ||
        if_p.block_count !== '0 || if_n.out_valid !== 1'b0 || if_n.block_count !== '0) begin
      fails++;
      $display("FAIL reset_outputs got valid=%b last=%b cnt=%0d expected all zero",
               if_p.out_valid, if_p.out_last, if_p.block_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_in_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_full_pad();
    byte_q_t msg;
    sel = 1'b0;
    do_reset();
    msg = ramp(8'h00, 16);
    push_expected(msg, 1'b1, 1'b1);
    send_msg(msg, 1'b1, 1'b0);
    drain();
    check_count("full_pad", 32'd2);
  endtask

  task automatic test_partial_pad();
    byte_q_t msg;
    sel = 1'b0;
    do_reset();
    msg = '{8'hAA, 8'hBB, 8'hCC};
    push_expected(msg, 1'b1, 1'b1);
    send_msg(msg, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL partial_latency out_valid got %b expected 1", out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL partial_after_accept in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    drain();
    check_count("partial_pad", 32'd1);
  endtask

  task automatic test_zero_fill();
    byte_q_t msg;
    sel = 1'b1;
    do_reset();
    msg = '{8'hAA, 8'hBB, 8'hCC};
    push_expected(msg, 1'b0, 1'b1);
    send_msg(msg, 1'b1, 1'b0);
    drain();
    check_count("zero_fill_partial", 32'd1);
    msg = ramp(8'h40, 16);
    push_expected(msg, 1'b0, 1'b1);
    send_msg(msg, 1'b1, 1'b0);
    drain();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL zero_fill_extra_block out_valid got %b expected 0", out_valid);
    end
    check_count("zero_fill_full", 32'd2);
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    byte_q_t msg;
    logic [127:0] first_blk;
    sel = 1'b0;
    do_reset();
    msg = ramp(8'h00, 20);
    push_expected(msg, 1'b1, 1'b1);
    first_blk = exp_q[0].blk;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(msg[i], 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_block !== first_blk || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold cycle %0d valid=%b in_ready=%b block=%h expected 1/0/%h",
                 c, out_valid, in_ready, out_block, first_blk);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_release in_ready got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    for (int i = 16; i < 20; i++) send_byte(msg[i], i == 19);
    drain();
    check_count("backpressure", 32'd2);
  endtask

  task automatic test_gapped();
    byte_q_t msg;
    sel = 1'b0;
    do_reset();
    msg = ramp(8'h00, 16);
    push_expected(msg, 1'b1, 1'b0);
    send_msg(msg, 1'b0, 1'b1);
    drain();
    check_count("gapped", 32'd1);
  endtask

  task automatic test_mid_reset();
    byte_q_t msg;
    logic seen_valid;
    sel = 1'b0;
    do_reset();
    send_msg(ramp(8'h80, 7), 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_valid = seen_valid | out_valid;
    end
    tests_run++;
    if (seen_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_valid out_valid got 1 expected 0");
    end
    check_count("mid_reset", 32'd0);
    @(posedge clk); #1;
    msg = ramp(8'h20, 16);
    push_expected(msg, 1'b1, 1'b0);
    send_msg(msg, 1'b0, 1'b0);
    drain();
    check_count("after_mid_reset", 32'd1);
  endtask

  initial begin
    sel       = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_full_pad();
    test_partial_pad();
    test_zero_fill();
    test_backpressure();
    test_gapped();
    test_mid_reset();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expected %0d blocks never seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
